// File: rtl/cpu_cache_pkg.sv
// Shared data-cache definitions: block geometry and the fill-controller state encoding.
package cpu_cache_pkg;

  localparam int unsigned BLOCK_WORDS = 8;
  localparam int unsigned OFF_W       = 3;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

endpackage

// File: rtl/fill_offset_ctr.sv
// Saturating word counter plus a start offset, producing the wrapped word index within a block.
module fill_offset_ctr #(
  parameter int unsigned BLOCK_WORDS = 8,
  parameter int unsigned OFF_W       = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [OFF_W-1:0] start_off,
  output logic [OFF_W-1:0] off_c,
  output logic             done_c,
  output logic             last_c
);

  localparam int unsigned CNT_W = OFF_W + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign done_c = (cnt_q == CNT_W'(BLOCK_WORDS));
  assign last_c = (cnt_q == CNT_W'(BLOCK_WORDS - 1));
  // Truncation to OFF_W bits gives the modulo-BLOCK_WORDS wrap.
  assign off_c  = start_off + cnt_q[OFF_W-1:0];

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !done_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cpu_dcache_fill.sv
// D-cache miss fill controller: fetches a whole block word by word and writes data/tag arrays.
// Define CACHE_FILL_CWF_EN for critical-word-first ordering; otherwise the block fills from word 0.
module cpu_dcache_fill #(
  parameter int unsigned BLOCK_WORDS = cpu_cache_pkg::BLOCK_WORDS,
  parameter int unsigned OFF_W       = cpu_cache_pkg::OFF_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             miss_detected,
  input  logic [15:0]      miss_address,
  input  logic [15:0]      memory_data,
  input  logic             memory_data_valid,
  output logic             fsm_busy,
  output logic             mem_req,
  output logic [15:0]      memory_address,
  output logic             write_data_array,
  output logic [OFF_W-1:0] fill_word_offset,
  output logic [15:0]      fill_data,
  output logic             write_tag_array,
  output logic             fill_critical
);

  import cpu_cache_pkg::fill_state_e;
  import cpu_cache_pkg::IDLE;
  import cpu_cache_pkg::FILL;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned BASE_W = ADDR_W - OFF_W - 1;

  fill_state_e       state_q, state_d;
  logic [BASE_W-1:0] base_q, base_d;
  logic [OFF_W-1:0]  miss_off_q, miss_off_d;
  logic [OFF_W-1:0]  start_off;
  logic              fill_start;
  logic              issue_inc, ret_inc;
  logic              issue_done, ret_done, ret_last;
  logic [OFF_W-1:0]  issue_off, ret_off;
  logic              issue_last_unused;
  logic              addr_lsb_unused;

  assign addr_lsb_unused = miss_address[0];

`ifdef CACHE_FILL_CWF_EN
  assign start_off = miss_off_q;
`else
  assign start_off = '0;
`endif

  fill_offset_ctr #(
    .BLOCK_WORDS (BLOCK_WORDS),
    .OFF_W       (OFF_W)
  ) u_issue_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (fill_start),
    .inc       (issue_inc),
    .start_off (start_off),
    .off_c     (issue_off),
    .done_c    (issue_done),
    .last_c    (issue_last_unused)
  );

  fill_offset_ctr #(
    .BLOCK_WORDS (BLOCK_WORDS),
    .OFF_W       (OFF_W)
  ) u_ret_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (fill_start),
    .inc       (ret_inc),
    .start_off (start_off),
    .off_c     (ret_off),
    .done_c    (ret_done),
    .last_c    (ret_last)
  );

  // Next-state and outputs; request side and return side run independently in FILL.
  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    miss_off_d       = miss_off_q;
    fill_start       = 1'b0;
    issue_inc        = 1'b0;
    ret_inc          = 1'b0;
    fsm_busy         = 1'b0;
    mem_req          = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    fill_word_offset = '0;
    write_tag_array  = 1'b0;
    case (state_q)
      IDLE: begin
        if (miss_detected) begin
          fsm_busy   = 1'b1;
          fill_start = 1'b1;
          base_d     = miss_address[ADDR_W-1:OFF_W+1];
          miss_off_d = miss_address[OFF_W:1];
          state_d    = FILL;
        end
      end
      FILL: begin
        fsm_busy = 1'b1;
        if (!issue_done) begin
          mem_req        = 1'b1;
          issue_inc      = 1'b1;
          memory_address = {base_q, issue_off, 1'b0};
        end
        if (memory_data_valid && !ret_done) begin
          write_data_array = 1'b1;
          ret_inc          = 1'b1;
          fill_word_offset = ret_off;
          if (ret_last) begin
            write_tag_array = 1'b1;
            state_d         = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fill_critical = write_data_array && (fill_word_offset == miss_off_q);
  assign fill_data     = memory_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      miss_off_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      miss_off_q <= miss_off_d;
    end
  end

endmodule

// File: tb/tb_cpu_dcache_fill.sv
// Scoreboard bench for cpu_dcache_fill: memory model with fixed latency, request/write queues.
module tb_cpu_dcache_fill;

  localparam int unsigned BW = 8;
  localparam int unsigned OW = 3;
`ifdef CACHE_FILL_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          miss_detected;
  logic [15:0]   miss_address;
  logic [15:0]   memory_data;
  logic          memory_data_valid;
  logic          fsm_busy;
  logic          mem_req;
  logic [15:0]   memory_address;
  logic          write_data_array;
  logic [OW-1:0] fill_word_offset;
  logic [15:0]   fill_data;
  logic          write_tag_array;
  logic          fill_critical;

  cpu_dcache_fill dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data       (memory_data),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .mem_req           (mem_req),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .fill_word_offset  (fill_word_offset),
    .fill_data         (fill_data),
    .write_tag_array   (write_tag_array),
    .fill_critical     (fill_critical)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OW-1:0] off;
    logic [15:0]   data;
  } wr_t;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_req_q[$];
  wr_t         exp_wr_q[$];
  logic [15:0] pend_addr[$];
  int          pend_rdy[$];

  int n_req, n_wr, n_tag, n_ret, busy_cnt;
  int first_req, first_wr, tag_cyc, crit_cyc;
  logic [OW-1:0] tag_off;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(fsm_busy), 32'd0);
    check({tag, "_req"}, 32'(mem_req), 32'd0);
    check({tag, "_addr"}, 32'(memory_address), 32'd0);
    check({tag, "_wr"}, 32'(write_data_array), 32'd0);
    check({tag, "_off"}, 32'(fill_word_offset), 32'd0);
    check({tag, "_tag"}, 32'(write_tag_array), 32'd0);
    check({tag, "_crit"}, 32'(fill_critical), 32'd0);
  endtask

  // One miss and its fill; the memory model answers each request lat cycles later.
  task automatic run_fill(input logic [15:0] maddr, input int lat, input int gap_cyc,
                          input bit stray, input bit miss_in_fill, input bit do_rst,
                          input bit chain, input logic [15:0] chain_addr);
    logic [15:0]   base;
    logic [15:0]   a;
    logic [OW-1:0] moff, start, o;
    bit            drv, rst_done;
    wr_t           e;
    base  = {maddr[15:OW+1], {(OW+1){1'b0}}};
    moff  = maddr[OW:1];
    start = CWF ? moff : '0;
    n_req = 0; n_wr = 0; n_tag = 0; n_ret = 0; busy_cnt = 0;
    first_req = -1; first_wr = -1; tag_cyc = -1; crit_cyc = -1; tag_off = '0;
    rst_done = 1'b0;
    if (stray) begin
      @(negedge clk);
      miss_detected = 1'b0; memory_data_valid = 1'b1; memory_data = 16'hDEAD;
      #1;
      check("stray_wr", 32'(write_data_array), 32'd0);
      check("stray_tag", 32'(write_tag_array), 32'd0);
      check("stray_busy", 32'(fsm_busy), 32'd0);
    end
    @(negedge clk);
    miss_detected = 1'b1; miss_address = maddr; memory_data_valid = 1'b0;
    for (int i = 0; i < int'(BW); i++) begin
      o = start + OW'(i);
      exp_req_q.push_back({base[15:OW+1], o, 1'b0});
    end
    #1;
    check("miss_busy", 32'(fsm_busy), 32'd1);
    check("miss_noreq", 32'(mem_req), 32'd0);
    if (fsm_busy) busy_cnt++;
    for (int c = 1; c < 200; c++) begin
      @(negedge clk);
      if (rst_done && pend_addr.size() == 0) begin
        memory_data_valid = 1'b0;
        break;
      end
      miss_detected = miss_in_fill && (c == 3);
      miss_address  = (miss_in_fill && (c == 3)) ? 16'hBEEF : maddr;
      if (do_rst && !rst_done && n_ret == 4) begin
        memory_data_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        #2;
        rst_n = 1'b1;
        rst_done = 1'b1;
        exp_req_q.delete();
        exp_wr_q.delete();
        continue;
      end
      drv = (pend_addr.size() > 0) && (pend_rdy[0] <= c) && !(c >= gap_cyc && c < gap_cyc + 3);
      memory_data_valid = drv;
      memory_data = 16'h0;
      if (drv) begin
        a = pend_addr.pop_front();
        void'(pend_rdy.pop_front());
        memory_data = mem_word(a);
        n_ret++;
        if (!rst_done) begin
          e.off = a[OW:1]; e.data = mem_word(a);
          exp_wr_q.push_back(e);
        end
        if (chain && !rst_done && n_ret == int'(BW)) begin
          miss_detected = 1'b1; miss_address = chain_addr;
        end
      end
      #1;
      if (rst_done) begin
        check("stale_wr", 32'(write_data_array), 32'd0);
        check("stale_busy", 32'(fsm_busy), 32'd0);
        continue;
      end
      if (fsm_busy) busy_cnt++;
      if (mem_req) begin
        n_req++;
        if (first_req < 0) first_req = c;
        if (exp_req_q.size() == 0) check("req_count", 32'(n_req), 32'(BW));
        else check("req_addr", 32'(memory_address), 32'(exp_req_q.pop_front()));
        pend_addr.push_back(memory_address);
        pend_rdy.push_back(c + lat);
      end
      check("wr_vs_valid", 32'(write_data_array), 32'(drv));
      if (write_data_array) begin
        n_wr++;
        if (first_wr < 0) first_wr = c;
        if (exp_wr_q.size() == 0) begin
          check("wr_count", 32'(n_wr), 32'(BW));
        end else begin
          e = exp_wr_q.pop_front();
          check("wr_off", 32'(fill_word_offset), 32'(e.off));
          check("wr_data", 32'(fill_data), 32'(e.data));
          check("crit", 32'(fill_critical), 32'(e.off == moff));
        end
        if (fill_critical) crit_cyc = c;
        check("tag_at_last", 32'(write_tag_array), 32'(n_wr == int'(BW)));
        if (write_tag_array) begin
          n_tag++; tag_cyc = c; tag_off = fill_word_offset;
        end
      end else begin
        check("tag_no_wr", 32'(write_tag_array), 32'd0);
      end
      if (n_tag > 0) break;
    end
    if (!rst_done) begin
      if (n_tag == 0) check("fill_timeout", 32'(n_tag), 32'd1);
      if (!chain) begin
        @(negedge clk);
        miss_detected = 1'b0; memory_data_valid = 1'b0;
        #1;
        check("idle_busy", 32'(fsm_busy), 32'd0);
        check("idle_req", 32'(mem_req), 32'd0);
      end
    end
  endtask

  task automatic check_fill(input string t, input int exp_busy, input int exp_first_wr,
                            input int exp_tag, input int moff);
    check({t, "_first_req"}, 32'(first_req), 32'd1);
    check({t, "_n_req"}, 32'(n_req), 32'(BW));
    check({t, "_n_wr"}, 32'(n_wr), 32'(BW));
    check({t, "_n_tag"}, 32'(n_tag), 32'd1);
    check({t, "_first_wr"}, 32'(first_wr), 32'(exp_first_wr));
    check({t, "_tag_cyc"}, 32'(tag_cyc), 32'(exp_tag));
    check({t, "_busy_cyc"}, 32'(busy_cnt), 32'(exp_busy));
    check({t, "_tag_off"}, 32'(tag_off), CWF ? 32'((moff + int'(BW) - 1) % int'(BW)) : 32'(BW - 1));
    if (exp_first_wr == exp_tag - int'(BW) + 1)
      check({t, "_crit_cyc"}, 32'(crit_cyc), CWF ? 32'(exp_first_wr) : 32'(exp_first_wr + moff));
  endtask

  initial begin
    rst_n = 1'b0; miss_detected = 1'b0; miss_address = '0;
    memory_data = '0; memory_data_valid = 1'b0;
    #1;
    check_all_zero("reset");
    check("reset_fill_data", 32'(fill_data), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Miss at 0x1236, latency 4.
    run_fill(16'h1236, 4, 999, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    check_fill("basic", 13, 5, 12, 3);

    // Returns withheld for cycles 7..9.
    run_fill(16'h1236, 4, 7, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    check_fill("gap", 16, 5, 15, 3);

    // Stray valid in IDLE, then a second miss raised mid-fill.
    run_fill(16'h4A5C, 3, 999, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    check_fill("stray", 12, 4, 11, 6);

    // Reset after the fourth return, then a fresh fill.
    run_fill(16'h1236, 4, 999, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    check("rst_n_wr", 32'(n_wr), 32'd4);
    check("rst_n_tag", 32'(n_tag), 32'd0);
    run_fill(16'h2E1A, 4, 999, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    check_fill("post_rst", 13, 5, 12, 5);

    // Back-to-back misses; the second is held high through the completing cycle.
    run_fill(16'h0000, 2, 999, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFF0);
    check_fill("b2b_a", 11, 3, 10, 0);
    run_fill(16'hFFF0, 2, 999, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    check_fill("b2b_b", 11, 3, 10, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
